ccff_chain_loader: RTL and testbench

Sequencer that programs a configuration-chain (ccff) segment of the fabric, such as a switch block's routing-mux memories. It accepts configuration words over a valid/ready stream, serializes them onto `ccff_head`, and gates the chain's shift clock. While the new bits shift in, it captures the old contents emerging at `ccff_tail` and returns them as a readback stream. It sits between the bitstream source and the head of one chain segment.

---
 rtl/ccff_ctrl_pkg.sv | 16 +
 rtl/ccff_serdes.sv | 82 ++++++++
 rtl/ccff_chain_loader.sv | 160 ++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_ctrl_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_serdes.sv
// Serializer for the chain head and deserializer for the chain tail readback.
module ccff_serdes
  import ccff_ctrl_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              shift_i,
  input  logic              tail_i,
  input  logic              flush_i,
  output logic              head_o,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  localparam int RB_W = cnt_w(WORD_W);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WORD_W-1:0] rbreg_q, rbreg_d;
  logic [RB_W-1:0]   rb_cnt_q, rb_cnt_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    sreg_d     = sreg_q;
    rbreg_d    = rbreg_q;
    rb_cnt_d   = rb_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (clear_i) begin
      sreg_d   = '0;
      rbreg_d  = '0;
      rb_cnt_d = '0;
    end else if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = sreg_q >> 1;
      for (int i = 0; i < WORD_W; i++) begin
        if (rb_cnt_q == RB_W'(i)) rbreg_d[i] = tail_i;
      end
      // A full word leaves on the same edge its last bit is captured.
      if (rb_cnt_q == RB_W'(WORD_W - 1)) begin
        rd_data_d  = rbreg_d;
        rd_valid_d = 1'b1;
        rbreg_d    = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_cnt_d = rb_cnt_q + RB_W'(1);
      end
    end else if (flush_i && (rb_cnt_q != '0)) begin
      rd_data_d  = rbreg_q;
      rd_valid_d = 1'b1;
      rbreg_d    = '0;
      rb_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q     <= '0;
      rbreg_q    <= '0;
      rb_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      rbreg_q    <= rbreg_d;
      rb_cnt_q   <= rb_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign head_o     = sreg_q[0];
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Programs one ccff chain segment from a word stream and returns the old
// chain contents as a readback stream.
module ccff_chain_loader
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 6,
  parameter int WORD_W    = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W  = cnt_w(CHAIN_LEN);
  localparam int SUB_W  = cnt_w(WORD_W);
  localparam int IDLE_W = cnt_w(TIMEOUT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              shift_en_q, shift_en_d;
  logic              sd_clear, sd_load, sd_shift, sd_flush;
  int                remain;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sub_cnt_d  = sub_cnt_q;
    idle_cnt_d = idle_cnt_q;
    done_d     = done_q;
    error_d    = error_q;
    sd_clear   = 1'b0;
    sd_load    = 1'b0;
    sd_shift   = 1'b0;
    sd_flush   = 1'b0;
    remain     = CHAIN_LEN - int'(bit_cnt_q);
    if (abort) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      sub_cnt_d  = '0;
      idle_cnt_d = '0;
      sd_clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            done_d     = 1'b0;
            error_d    = 1'b0;
            bit_cnt_d  = '0;
            idle_cnt_d = '0;
            sd_clear   = 1'b1;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            sd_load = 1'b1;
            // The last word is trimmed so no bit lands beyond the chain end.
            sub_cnt_d = (remain < WORD_W) ? SUB_W'(remain) : SUB_W'(WORD_W);
            state_d   = SHIFT;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            if (idle_cnt_d == IDLE_W'(TIMEOUT)) begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
        SHIFT: begin
          sd_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          sub_cnt_d = sub_cnt_q - SUB_W'(1);
          if (sub_cnt_d == '0) begin
            if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
              state_d = DRAIN;
            end else begin
              state_d    = LOAD;
              idle_cnt_d = '0;
            end
          end
        end
        DRAIN: begin
          sd_flush = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Outputs are registered from the next state so they line up with it.
    busy_d     = (state_d == LOAD) || (state_d == SHIFT);
    ready_d    = (state_d == LOAD);
    shift_en_d = (state_d == SHIFT);
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sub_cnt_q  <= '0;
      idle_cnt_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      done_q     <= done_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      shift_en_q <= shift_en_d;
    end
  end

  ccff_serdes #(
    .WORD_W(WORD_W)
  ) u_serdes (
    .clk       (prog_clk),
    .rst_n     (prog_reset_n),
    .clear_i   (sd_clear),
    .load_i    (sd_load),
    .data_i    (cfg_data),
    .shift_i   (sd_shift),
    .tail_i    (ccff_tail),
    .flush_i   (sd_flush),
    .head_o    (ccff_head),
    .rd_data_o (rd_data),
    .rd_valid_o(rd_valid)
  );

  assign cfg_ready     = ready_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 6-bit and a 20-bit chain model, with
// scoreboards for head bits, shift-burst lengths and readback words.
module tb_ccff_chain_loader;

  localparam logic [5:0]  C6_INIT  = 6'b100110;
  localparam logic [19:0] C20_INIT = 20'h9B3E1;

  logic clk = 1'b0;
  logic rst_n;
  logic pre;
  always #5 clk = ~clk;

  logic       st6, ab6, v6, rdy6, head6, se6, tail6, rv6, busy6, done6, err6;
  logic [7:0] d6, rd6;
  logic       st20, ab20, v20, rdy20, head20, se20, tail20, rv20, busy20, done20, err20;
  logic [7:0] d20, rd20;

  logic [5:0]  chain6;
  logic [19:0] chain20;
  logic [5:0]  exp6;
  logic [19:0] exp20;

  logic       hq6[$];
  logic       hq20[$];
  int         bq6[$];
  int         bq20[$];
  logic [7:0] rq6[$];
  logic [7:0] rq20[$];

  int checks = 0;
  int failures = 0;

  ccff_chain_loader dut6 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(st6), .abort(ab6),
    .cfg_data(d6), .cfg_valid(v6), .cfg_ready(rdy6), .ccff_head(head6),
    .ccff_shift_en(se6), .ccff_tail(tail6), .rd_data(rd6), .rd_valid(rv6),
    .busy(busy6), .done(done6), .error(err6)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .TIMEOUT(255)) dut20 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(st20), .abort(ab20),
    .cfg_data(d20), .cfg_valid(v20), .cfg_ready(rdy20), .ccff_head(head20),
    .ccff_shift_en(se20), .ccff_tail(tail20), .rd_data(rd20), .rd_valid(rv20),
    .busy(busy20), .done(done20), .error(err20)
  );

  // Chain models: index 0 is the FF driving the tail.
  always @(posedge clk) begin
    if (pre) chain6 <= C6_INIT;
    else if (se6) chain6 <= {head6, chain6[5:1]};
    if (pre) chain20 <= C20_INIT;
    else if (se20) chain20 <= {head20, chain20[19:1]};
  end
  assign tail6  = chain6[0];
  assign tail20 = chain20[0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops scoreboards away from the active edge.
  initial begin
    int run6, run20;
    run6 = 0;
    run20 = 0;
    forever begin
      @(negedge clk);
      if (se6) begin
        run6++;
        if (hq6.size() > 0) check_eq("head6", head6, hq6.pop_front());
        else check_eq("head6_unexp", se6, 0);
      end else if (run6 > 0) begin
        if (bq6.size() > 0) check_eq("burst6", run6, bq6.pop_front());
        else check_eq("burst6_unexp", run6, 0);
        run6 = 0;
      end
      if (rv6) begin
        if (rq6.size() > 0) check_eq("rd6", rd6, rq6.pop_front());
        else check_eq("rd6_unexp", rv6, 0);
      end
      if (se20) begin
        run20++;
        if (hq20.size() > 0) check_eq("head20", head20, hq20.pop_front());
        else check_eq("head20_unexp", se20, 0);
      end else if (run20 > 0) begin
        if (bq20.size() > 0) check_eq("burst20", run20, bq20.pop_front());
        else check_eq("burst20_unexp", run20, 0);
        run20 = 0;
      end
      if (rv20) begin
        if (rq20.size() > 0) check_eq("rd20", rd20, rq20.pop_front());
        else check_eq("rd20_unexp", rv20, 0);
      end
    end
  end

  task automatic load6(input logic [7:0] w);
    int n;
    logic r;
    for (int i = 0; i < 6; i++) hq6.push_back(w[i]);
    bq6.push_back(6);
    rq6.push_back({2'b00, exp6});
    exp6 = w[5:0];
    @(posedge clk); #1 st6 = 1'b1;
    @(posedge clk); #1 st6 = 1'b0;
    check_eq("done_clr6", done6, 0);
    v6 = 1'b1;
    d6 = w;
    n = 0;
    while (!done6 && n < 40) begin
      r = rdy6;
      @(posedge clk); #1;
      n++;
      if (r && v6) v6 = 1'b0;
    end
    check_eq("lat6", n, 8);
    check_eq("done6", done6, 1);
    check_eq("chain6", chain6, exp6);
  endtask

  task automatic load20(input logic [23:0] ws);
    int n, idx;
    logic r;
    for (int i = 0; i < 20; i++) hq20.push_back(ws[i]);
    bq20.push_back(8);
    bq20.push_back(8);
    bq20.push_back(4);
    rq20.push_back(exp20[7:0]);
    rq20.push_back(exp20[15:8]);
    rq20.push_back({4'b0000, exp20[19:16]});
    exp20 = ws[19:0];
    @(posedge clk); #1 st20 = 1'b1;
    @(posedge clk); #1 st20 = 1'b0;
    v20 = 1'b1;
    idx = 0;
    d20 = ws[7:0];
    n = 0;
    while (!done20 && n < 80) begin
      r = rdy20;
      @(posedge clk); #1;
      n++;
      if (r && v20) begin
        idx++;
        if (idx < 3) d20 = ws[8*idx +: 8];
        else v20 = 1'b0;
      end
    end
    check_eq("lat20", n, 24);
    check_eq("done20", done20, 1);
    check_eq("chain20", chain20, exp20);
  endtask

  // Start a 6-bit load and return in the first shift cycle.
  task automatic begin6(input logic [7:0] w);
    @(posedge clk); #1 st6 = 1'b1;
    @(posedge clk); #1 st6 = 1'b0;
    v6 = 1'b1;
    d6 = w;
    @(posedge clk); #1 v6 = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] w;
    rst_n = 1'b0; pre = 1'b1;
    st6 = 0; ab6 = 0; v6 = 0; d6 = '0;
    st20 = 0; ab20 = 0; v20 = 0; d20 = '0;
    exp6 = C6_INIT;
    exp20 = C20_INIT;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out6", {rdy6, head6, se6, rd6, rv6, busy6, done6, err6}, 0);
    check_eq("rst_out20", {rdy20, head20, se20, rd20, rv20, busy20, done20, err20}, 0);
    pre = 1'b0;
    rst_n = 1'b1;

    // Basic load, then a round trip whose readback is the first word
    load6(8'h2D);
    load6(8'h15);
    load6(8'h2A);

    // Multi-word on the 20-bit chain; upper nibble of word 3 must not shift
    load20(24'hF6_5A3C);
    load20(24'h3C_9A71);

    // Abort during the third shift cycle
    w = 8'h3C;
    for (int i = 0; i < 3; i++) hq6.push_back(w[i]);
    bq6.push_back(3);
    begin6(w);
    @(posedge clk); #1;
    @(posedge clk); #1 ab6 = 1'b1;
    @(posedge clk); #1 ab6 = 1'b0;
    check_eq("abort_se", se6, 0);
    check_eq("abort_busy", busy6, 0);
    check_eq("abort_done", done6, 0);
    exp6 = {w[2:0], exp6[5:3]};
    check_eq("abort_chain", chain6, exp6);
    repeat (3) @(posedge clk);

    // Timeout with no words offered
    #1 st6 = 1'b1;
    @(posedge clk); #1 st6 = 1'b0;
    n = 0;
    while (!err6 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("tmo_cycles", n, 255);
    check_eq("tmo_err", err6, 1);
    check_eq("tmo_busy", busy6, 0);
    check_eq("tmo_chain", chain6, exp6);
    st6 = 1'b1;
    @(posedge clk); #1 st6 = 1'b0;
    check_eq("tmo_err_clr", err6, 0);
    check_eq("tmo_rdy", rdy6, 1);
    ab6 = 1'b1;
    @(posedge clk); #1 ab6 = 1'b0;
    check_eq("tmo_abort_busy", busy6, 0);

    // Start and abort together: abort wins
    st6 = 1'b1; ab6 = 1'b1;
    @(posedge clk); #1 st6 = 1'b0; ab6 = 1'b0;
    check_eq("st_ab_busy", busy6, 0);
    check_eq("st_ab_rdy", rdy6, 0);

    // Asynchronous reset mid-shift, then a normal load
    w = 8'h0F;
    hq6.push_back(w[0]);
    hq6.push_back(w[1]);
    bq6.push_back(2);
    begin6(w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out6", {rdy6, head6, se6, rd6, rv6, busy6, done6, err6}, 0);
    pre = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pre = 1'b0;
    rst_n = 1'b1;
    exp6 = C6_INIT;
    load6(8'h33);

    repeat (4) @(posedge clk);
    #1;
    check_eq("q6_left", hq6.size() + bq6.size() + rq6.size(), 0);
    check_eq("q20_left", hq20.size() + bq20.size() + rq20.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
